// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search block.
// Holds the FSM state encoding and a helper that gives the number of cycles
// from the start-accept cycle to the done cycle for a given configuration.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TEST   = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_t;

    // One TEST edge per bit, each preceded by `settle` wait edges, plus the
    // cycle in which start is presented.
    function automatic int latency(input int width, input int settle);
        return width * (settle + 1) + 1;
    endfunction

endpackage

// File: rtl/sar_search.sv
// sar_search: successive-approximation search against an external
// greater-than comparator (a = trial, b = hidden target).  Bits are decided
// MSB first; a 1 on gt_in means the trial overshot, so the bit under test is
// cleared.  After WIDTH decisions the trial equals the target.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, overrides everything
//   start  : request a new search, only accepted in IDLE
//   gt_in  : comparator answer, 1 when trial > target (sampled in TEST only)
//   trial  : code presented to the comparator
//   busy   : high while a search is in progress, including the done cycle
//   done   : one-cycle pulse, result valid from this cycle on
//   result : recovered target, held until the next accepted start
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt_in,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam int               MSB_I  = 1 << (WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB    = MSB_I[WIDTH-1:0];
    localparam int               TOP_I  = WIDTH - 1;
    localparam logic [IDX_W-1:0] TOP    = TOP_I[IDX_W-1:0];

    // Counter reload value; SETTLE=0 never enters the SETTLE state, so the
    // value is irrelevant there and is kept at zero.
    localparam int          SETTLE_LOAD_I = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [3:0]  SETTLE_LOAD   = SETTLE_LOAD_I[3:0];

    // State entered after each trial update: wait first if the comparator
    // path needs settling time, otherwise test on the very next edge.
    localparam sar_state_t AFTER_UPDATE = (SETTLE > 0) ? ST_SETTLE : ST_TEST;

    sar_state_t       state, state_n;
    logic [IDX_W-1:0] bit_idx, bit_n;
    logic [3:0]       cnt, cnt_n;
    logic [WIDTH-1:0] trial_n, result_n;
    logic             busy_n, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            trial   <= '0;
            result  <= '0;
            bit_idx <= TOP;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            trial   <= trial_n;
            result  <= result_n;
            bit_idx <= bit_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        trial_n  = trial;
        result_n = result;
        bit_n    = bit_idx;
        cnt_n    = cnt;
        busy_n   = busy;
        done_n   = done;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    trial_n = MSB;
                    bit_n   = TOP;
                    cnt_n   = SETTLE_LOAD;
                    busy_n  = 1'b1;
                    state_n = AFTER_UPDATE;
                end
            end

            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_n = ST_TEST;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end

            ST_TEST: begin
                // Overshoot: the bit under test must be zero in the target.
                if (gt_in) begin
                    trial_n[bit_idx] = 1'b0;
                end
                if (bit_idx != '0) begin
                    trial_n[bit_idx - IDX_W'(1)] = 1'b1;
                    bit_n   = bit_idx - IDX_W'(1);
                    cnt_n   = SETTLE_LOAD;
                    state_n = AFTER_UPDATE;
                end else begin
                    // Last decision: capture including this cycle's clear.
                    result_n = trial_n;
                    done_n   = 1'b1;
                    state_n  = ST_DONE;
                end
            end

            ST_DONE: begin
                done_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_now = 0;

    // WIDTH=4, SETTLE=0
    logic       start4;
    logic [3:0] tgt4;
    logic       gt4;
    logic [3:0] trial4, result4;
    logic       busy4, done4;
    assign gt4 = (trial4 > tgt4);

    // WIDTH=2, SETTLE=0
    logic       start2;
    logic [1:0] tgt2;
    logic       gt2;
    logic [1:0] trial2, result2;
    logic       busy2, done2;
    assign gt2 = (trial2 > tgt2);

    // WIDTH=4, SETTLE=2, with gt_in scrambled outside the TEST edges
    logic       start4s;
    logic [3:0] tgt4s;
    logic       gt4s;
    logic       rnd_mode, rnd_bit;
    logic [3:0] trial4s, result4s;
    logic       busy4s, done4s;
    assign gt4s = rnd_mode ? rnd_bit : (trial4s > tgt4s);

    sar_search #(.WIDTH(4), .SETTLE(0)) u4 (
        .clk(clk), .rst(rst), .start(start4), .gt_in(gt4),
        .trial(trial4), .busy(busy4), .done(done4), .result(result4)
    );

    sar_search #(.WIDTH(2), .SETTLE(0)) u2 (
        .clk(clk), .rst(rst), .start(start2), .gt_in(gt2),
        .trial(trial2), .busy(busy2), .done(done2), .result(result2)
    );

    sar_search #(.WIDTH(4), .SETTLE(2)) u4s (
        .clk(clk), .rst(rst), .start(start4s), .gt_in(gt4s),
        .trial(trial4s), .busy(busy4s), .done(done4s), .result(result4s)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc_now++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start on the W=4/S=0 instance and count steps until done rises.
    task automatic run4(input logic [3:0] target, output int cycles);
        tgt4   = target;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        cycles = 1;
        while (!done4 && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int last;
        rst = 1'b1;
        start4 = 1'b0; start2 = 1'b0; start4s = 1'b0;
        tgt4 = 4'd0; tgt2 = 2'd0; tgt4s = 4'd0;
        rnd_mode = 1'b1; rnd_bit = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_trial", trial4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_result", result4, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_busy4s", busy4s, 0);
        step();
        chk("idle_hold_busy", busy4, 0);

        // Target 11: trial walk 1000, 1100, 1010, 1011
        tgt4 = 4'd11;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("t11_trial0", trial4, 4'b1000);
        chk("t11_busy", busy4, 1);
        step();
        chk("t11_trial1", trial4, 4'b1100);
        step();
        chk("t11_trial2", trial4, 4'b1010);
        step();
        chk("t11_trial3", trial4, 4'b1011);
        chk("t11_not_done", done4, 0);
        step();
        chk("t11_done", done4, 1);
        chk("t11_busy_done", busy4, 1);
        chk("t11_result", result4, 11);
        step();
        chk("t11_done_drop", done4, 0);
        chk("t11_busy_drop", busy4, 0);
        chk("t11_result_hold", result4, 11);

        // Boundary targets
        run4(4'd0, cyc);
        chk("t0_latency", cyc, 5);
        chk("t0_result", result4, 0);
        chk("t0_trial", trial4, 4'b0000);
        step();
        run4(4'd15, cyc);
        chk("t15_latency", cyc, 5);
        chk("t15_result", result4, 15);
        chk("t15_trial", trial4, 4'b1111);
        step();

        // WIDTH=2 back-to-back with start held high
        start2 = 1'b1;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            tgt2 = k[1:0];
            cyc = 0;
            while (!done2 && cyc < 20) begin
                step();
                cyc++;
            end
            chk("b2b_done", done2, 1);
            chk("b2b_result", result2, k);
            if (k > 0) chk("b2b_period", cyc_now - last, 4);
            last = cyc_now;
            if (k == 3) start2 = 1'b0;
            step();
        end
        step();
        chk("b2b_idle", busy2, 0);

        // SETTLE=2, target 6; gt_in random except at TEST edges (every third)
        tgt4s = 4'd6;
        rnd_bit = 1'($urandom_range(0, 1));
        start4s = 1'b1;
        step();
        start4s = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            rnd_mode = (k % 3 != 0);
            rnd_bit  = 1'($urandom_range(0, 1));
            step();
            if (k == 3)  chk("s2_trial_e3", trial4s, 4'b0100);
            if (k == 6)  chk("s2_trial_e6", trial4s, 4'b0110);
            if (k == 9)  chk("s2_trial_e9", trial4s, 4'b0111);
            if (k == 11) chk("s2_not_done", done4s, 0);
        end
        chk("s2_done_13", done4s, 1);
        chk("s2_result", result4s, 6);
        rnd_mode = 1'b1;
        rnd_bit  = 1'($urandom_range(0, 1));
        step();
        chk("s2_busy_drop", busy4s, 0);

        // start held high through a whole search: no restart
        tgt4 = 4'd5;
        start4 = 1'b1;
        cyc = 0;
        while (!done4 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("hold_latency", cyc, 5);
        chk("hold_result", result4, 5);
        start4 = 1'b0;
        step();
        chk("hold_busy_drop", busy4, 0);
        step();
        chk("hold_single", busy4, 0);

        // Reset in the second TEST cycle aborts and clears
        tgt4 = 4'd11;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_trial", trial4, 0);
        chk("abort_result", result4, 0);
        run4(4'd9, cyc);
        chk("after_abort_latency", cyc, 5);
        chk("after_abort_result", result4, 9);
        step();
        chk("after_abort_idle", busy4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Sequential counterpart of the combinational magnitude comparator. It drives trial codes into an external "greater-than" comparator (a = trial, b = unknown target) and reads back gt.
- Binary-searches MSB-first (successive approximation) to recover the unknown target value.
- Sits on the opposite side of the comparator interface: the comparator answers, this block asks.
- Used wherever a hidden or analog-side quantity is exposed only through a compare result.

Parameters:
- WIDTH, 4, bit width of trial/result; legal range 1..16.
- SETTLE, 0, wait cycles after each trial update before gt_in is sampled (for registered comparators or slow paths); legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset.
- start  input  1  request a new search; accepted only in IDLE.
- gt_in  input  1  comparator result, 1 when trial > target.
- trial  output  WIDTH  code presented to comparator input a.
- busy  output  1  high from the cycle after start is accepted until the cycle after done.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  WIDTH  recovered target; held until the next accepted start.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). rst overrides all other inputs at any state, including mid-search.
- Reset values: state=IDLE, trial=0, busy=0, done=0, result=0, bit index=WIDTH-1, settle counter=0.
- States: IDLE, SETTLE, TEST, DONE.
- IDLE:
  - start=1 at edge E0 -> trial <= 1<<(WIDTH-1), bit index <= WIDTH-1, busy <= 1.
  - Next state is SETTLE if SETTLE>0 (counter loaded with SETTLE-1); otherwise TEST.
  - start=0 -> hold; trial holds its last value.
- SETTLE: decrement the counter each cycle; at counter==0 go to TEST. gt_in is ignored in this state.
- TEST (sample gt_in at the edge):
  - If gt_in=1, clear trial[bit]; otherwise keep it.
  - If bit>0: set trial[bit-1], bit <= bit-1, then go to SETTLE (counter reload) or stay in TEST.
  - If bit==0: result <= final trial value (including this cycle's clear), done <= 1, go to DONE.
- DONE:
  - done=1 and busy=1 for exactly this one cycle.
  - Next edge: done <= 0, busy <= 0, go to IDLE.
  - start is ignored in DONE.
- Latency, start edge to done high: WIDTH*(SETTLE+1)+1 cycles. With WIDTH=4 and SETTLE=0, done is high in the cycle after edge E4.
- start while busy (SETTLE/TEST/DONE) is ignored. There is no queuing and the search is not restarted.
- Back-to-back: start high in the first IDLE cycle after DONE is accepted. Minimum period is WIDTH*(SETTLE+1)+2 cycles.
- gt_in must be stable at every TEST edge. An X on gt_in during IDLE/SETTLE/DONE has no effect.
- Boundary values:
  - target=0: every bit is cleared, result=0.
  - target=2^WIDTH-1: gt_in is never 1, result is all ones.
- WIDTH=1: a single TEST cycle.
- result is not updated by an aborted search (rst clears it to 0).

Decomposition:
- Shared package/header sar_pkg: state encoding constants (IDLE=2'd0, SETTLE=2'd1, TEST=2'd2, DONE=2'd3) and a LATENCY(WIDTH,SETTLE) function for the bench.
- No sub-module is needed; this is a single FSM plus the trial register and settle counter.
- The bench instantiates the existing 2-bit greater module as the comparator for WIDTH=2 and a behavioural compare model for other widths.

Test Plan:
- WIDTH=4, SETTLE=0, target=4'b1011, pulse start -> trial sequence 1000, 1100, 1010, 1011; done pulses 5 cycles after start; result=11; busy drops with done.
- WIDTH=4, targets 0 and 15 -> result 0 and 15; trial ends at 0000 and 1111 respectively.
- WIDTH=2 using the greater comparator, targets 0..3 swept with back-to-back starts -> result equals target each time; period is 4 cycles.
- WIDTH=4, SETTLE=2, target=6 -> done 13 cycles after start; gt_in toggled randomly during SETTLE cycles has no effect; result=6.
- start held high throughout a search -> exactly one search per IDLE visit; no restart mid-search; result=target.
- rst asserted in the second TEST cycle -> next cycle busy=0, done=0, trial=0, result=0; a new start then completes normally.
